// File: rtl/fifo_pkg.sv
// Shared types, default FIFO constants and the round-robin next-grant helper
// used by the FIFO write-port arbiter.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int RR_MAX     = 8;

    // One-hot grant for the first set req at or after owner+1, wrapping modulo n.
    function automatic logic [RR_MAX-1:0] rr_next(
        input logic [RR_MAX-1:0] req,
        input logic [2:0]        owner,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        logic [2:0]        idx;
        grant = {RR_MAX{1'b0}};
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = 3'((32'(owner) + k) % n);
            if ((k <= n) && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                grant = grant;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after 'start'
// (wrapping modulo N), returned as one-hot, index and valid flag.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [RR_MAX-1:0] req_ext_s;
    logic [RR_MAX-1:0] grant_s;
    logic [2:0]        prev_s;

    // rr_next scans from the slot after its argument, so hand it start-1.
    always_comb begin
        req_ext_s         = {RR_MAX{1'b0}};
        req_ext_s[N-1:0]  = req;
        prev_s            = (start == {IDX_W{1'b0}}) ? 3'(N - 1) : (3'(start) - 3'd1);
        grant_s           = rr_next(req_ext_s, prev_s, N);
        onehot            = grant_s[N-1:0];
        valid             = |grant_s;
        idx               = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | ({IDX_W{grant_s[i]}} & IDX_W'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accepted-word counters.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int  MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            req_pop,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          arb_err
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic [IDX_W-1:0]              stat_sel,
    output logic [15:0]                   stat_cnt
`endif
);

    arb_state_t          state_q;
    logic [IDX_W-1:0]    owner_q;
    logic [CNT_W-1:0]    burst_cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                wr_pend_q;
    logic                arb_err_q;

    logic [IDX_W-1:0]    start_s;
    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_valid_s;
    logic                pop_any_s;
    logic                owner_req_s;
    logic                release_s;

    // Datapath: accept rule, write enable and granted-data mux.
    always_comb begin
        req_pop      = gnt_q & req & {NUM_REQ{~fifo_full}};
        pop_any_s    = |req_pop;
        fifo_wr_en   = pop_any_s;
        fifo_data_in = {FIFO_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data_in = fifo_data_in |
                ({FIFO_WIDTH{gnt_q[i]}} & req_data[i*FIFO_WIDTH +: FIFO_WIDTH]);
        end
        owner_req_s = |(gnt_q & req);
        release_s   = (pop_any_s && (burst_cnt_q == CNT_W'(MAX_BURST - 1))) || !owner_req_s;
        start_s     = (owner_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (owner_q + IDX_W'(1));
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (start_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Grant FSM plus the write-acknowledge / overflow protocol monitor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= {CNT_W{1'b0}};
            gnt_q       <= {NUM_REQ{1'b0}};
            wr_pend_q   <= 1'b0;
            arb_err_q   <= 1'b0;
        end else begin
            wr_pend_q <= fifo_wr_en;
            arb_err_q <= arb_err_q | (wr_pend_q ^ fifo_wr_ack) | fifo_overflow;
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        gnt_q       <= pick_onehot_s;
                        owner_q     <= pick_idx_s;
                        burst_cnt_q <= {CNT_W{1'b0}};
                        state_q     <= BURST;
                    end else begin
                        gnt_q       <= {NUM_REQ{1'b0}};
                        burst_cnt_q <= {CNT_W{1'b0}};
                        state_q     <= IDLE;
                    end
                end
                BURST: begin
                    // Old owner sits last in the scan, so it only wins if alone.
                    if (release_s) begin
                        burst_cnt_q <= {CNT_W{1'b0}};
                        if (pick_valid_s) begin
                            gnt_q   <= pick_onehot_s;
                            owner_q <= pick_idx_s;
                            state_q <= BURST;
                        end else begin
                            gnt_q   <= {NUM_REQ{1'b0}};
                            state_q <= IDLE;
                        end
                    end else if (pop_any_s) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end else begin
                        burst_cnt_q <= burst_cnt_q;
                    end
                end
                default: begin
                    gnt_q       <= {NUM_REQ{1'b0}};
                    burst_cnt_q <= {CNT_W{1'b0}};
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign arb_err = arb_err_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    // Saturating per-requester accepted-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_pop[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'h0001;
                end else begin
                    stat_q[i] <= stat_q[i];
                end
            end
        end
    end

    // Out-of-range selects match no entry and read back as zero.
    always_comb begin
        stat_cnt = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt = stat_cnt | ({16{stat_sel == IDX_W'(i)}} & stat_q[i]);
        end
    end
`endif

endmodule
